// File: rtl/bus_seq_pkg.sv
// Shared types and defaults for the bus transfer sequencer: control-step
// states, command op encodings and default field widths.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    ALU_T1,
    ALU_T2,
    ALU_T3
  } seq_state_e;

  localparam logic OP_MOVE = 1'b0;
  localparam logic OP_ALU  = 1'b1;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_IDX_W    = 4;
  localparam int DEF_ALU_OP_W = 4;

endpackage

// File: rtl/onehot_decoder.sv
// Register index to one-hot select; indices beyond NUM_REGS give an all-zero
// vector and clear in_range.
module onehot_decoder #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot,
  output logic                in_range
);

  always_comb begin
    in_range = ({1'b0, idx} < NUM_REGS[IDX_W:0]);
    onehot   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = in_range && (idx == i[IDX_W-1:0]);
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Control-step sequencer for the shared 32-bit register bus: takes one MOVE or
// ALU command at a time and drives register selects, Y/Z controls and the ALU op.
module bus_transfer_sequencer
  import bus_seq_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int ALU_OP_W = DEF_ALU_OP_W
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [IDX_W-1:0]    cmd_src_a,
  input  logic [IDX_W-1:0]    cmd_src_b,
  input  logic [IDX_W-1:0]    cmd_dst,
  input  logic [ALU_OP_W-1:0] cmd_alu,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                y_in,
  output logic                z_in,
  output logic                z_out,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                done,
  output logic                err
);

  seq_state_e          state, next_state;
  logic [IDX_W-1:0]    src_a_q, src_b_q, dst_q;
  logic [ALU_OP_W-1:0] alu_q;
  logic                bad_q;

  logic                accept;
  logic [IDX_W-1:0]    src_sel;
  logic [NUM_REGS-1:0] src_onehot, dst_onehot;
  logic                src_ok, dst_ok;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Only ALU_T2 puts source B on the bus; every other bus-driving step uses A.
  assign src_sel   = (state == ALU_T2) ? src_b_q : src_a_q;

  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_src_dec (
    .idx      (src_sel),
    .onehot   (src_onehot),
    .in_range (src_ok)
  );

  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dst_dec (
    .idx      (dst_q),
    .onehot   (dst_onehot),
    .in_range (dst_ok)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state   <= IDLE;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      alu_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        src_a_q <= cmd_src_a;
        src_b_q <= cmd_src_b;
        dst_q   <= cmd_dst;
        alu_q   <= cmd_alu;
        bad_q   <= 1'b0;
      end else if ((state == ALU_T1 || state == ALU_T2) && !src_ok) begin
        // Remember a bad ALU source until the final step reports it.
        bad_q <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    reg_out    = '0;
    reg_in     = '0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    z_out      = 1'b0;
    alu_op     = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = (cmd_op == OP_ALU) ? ALU_T1 : MOVE;
      end
      MOVE: begin
        reg_out    = src_onehot;
        reg_in     = dst_onehot;
        done       = 1'b1;
        err        = !src_ok || !dst_ok;
        next_state = IDLE;
      end
      ALU_T1: begin
        reg_out    = src_onehot;
        y_in       = 1'b1;
        next_state = ALU_T2;
      end
      ALU_T2: begin
        reg_out    = src_onehot;
        alu_op     = alu_q;
        z_in       = 1'b1;
        next_state = ALU_T3;
      end
      ALU_T3: begin
        z_out      = 1'b1;
        reg_in     = dst_onehot;
        done       = 1'b1;
        err        = bad_q || !dst_ok;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
